tv_check_engine: RTL and testbench

Synthesizable, parametrised self-check engine that replays stored test vectors into a combinational or short-latency DUT and compares the DUT response against expected values. It generalises our testbench vector-replay flow into hardware: configurable input/output widths, vector depth and settle time, with on-chip error counting. It sits beside the DUT on the lab board or in simulation. A host loads the vectors, pulses start, and reads pass/fail.

---
 rtl/tv_check_pkg.sv | 34 +++
 rtl/tv_check_engine_if.sv | 40 ++++
 rtl/tv_vec_mem.sv | 60 ++++++
 rtl/tv_check_engine.sv | 161 ++++++++++++++++
 tb/tb_tv_check_engine.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tv_check_pkg.sv
// Shared types and entry-layout helpers for the test-vector check engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Entry layout, MSB first: {valid, in[IN_W-1:0], expected[OUT_W-1:0]}.
package tv_check_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Total bits in one stored vector entry.
    function automatic int entry_w(input int in_w, input int out_w);
        return 1 + in_w + out_w;
    endfunction

    // Bit position of the valid flag (entry MSB).
    function automatic int valid_pos(input int in_w, input int out_w);
        return in_w + out_w;
    endfunction

    // LSB of the stimulus field; it sits directly above the expected field.
    function automatic int in_lsb(input int out_w);
        return out_w;
    endfunction

    // LSB of the expected-response field.
    function automatic int exp_lsb();
        return 0;
    endfunction

endpackage

// File: rtl/tv_check_engine_if.sv
// Host/DUT-side bundle for the check engine: vector load, run control, results, DUT pins.
// Latency: n/a (wiring only).
// Backpressure: none; vector writes are dropped while the engine reports busy.
// Modports: master = host plus DUT under test (drives start, vec_*, dut_out);
//           slave  = check engine (drives dut_in and all status/result signals).
interface tv_check_if #(
    parameter int IN_W   = 3,
    parameter int OUT_W  = 1,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int CNT_W  = ADDR_W + 1
);
    logic                    start;
    logic                    vec_we;
    logic [ADDR_W-1:0]       vec_waddr;
    logic [IN_W+OUT_W:0]     vec_wdata;
    logic [IN_W-1:0]         dut_in;
    logic [OUT_W-1:0]        dut_out;
    logic                    busy;
    logic                    done;
    logic                    pass;
    logic                    mismatch;
    logic [CNT_W-1:0]        vec_count;
    logic [CNT_W-1:0]        err_count;
    logic                    first_err_valid;
    logic [ADDR_W-1:0]       first_err_idx;
    logic [OUT_W-1:0]        first_err_got;

    modport master (
        output start, vec_we, vec_waddr, vec_wdata, dut_out,
        input  dut_in, busy, done, pass, mismatch, vec_count, err_count,
               first_err_valid, first_err_idx, first_err_got
    );

    modport slave (
        input  start, vec_we, vec_waddr, vec_wdata, dut_out,
        output dut_in, busy, done, pass, mismatch, vec_count, err_count,
               first_err_valid, first_err_idx, first_err_got
    );
endinterface

// File: rtl/tv_vec_mem.sv
// Vector store: DEPTH x entry register array, one write port, two combinational read ports.
// Latency: reads are combinational; a write is visible the cycle after it is presented.
// Backpressure: none; the caller gates we. Only valid bits are reset (cleared), data is not.
// Ports: clk/reset, we/waddr/wdata write port; raddr_hd -> rdata_hd {valid,in};
//        raddr_exp -> rdata_exp (expected field only). Out-of-range reads return 0.
module tv_vec_mem
    import tv_check_pkg::*;
#(
    parameter int IN_W   = 3,
    parameter int OUT_W  = 1,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      we,
    input  logic [ADDR_W-1:0]         waddr,
    input  logic [IN_W+OUT_W:0]       wdata,
    input  logic [ADDR_W-1:0]         raddr_hd,
    output logic [IN_W:0]             rdata_hd,
    input  logic [ADDR_W-1:0]         raddr_exp,
    output logic [OUT_W-1:0]          rdata_exp
);
    localparam int VP = valid_pos(IN_W, OUT_W);
    localparam int IL = in_lsb(OUT_W);
    localparam int EL = exp_lsb();

    logic [DEPTH-1:0] vld;
    logic [IN_W-1:0]  in_mem  [DEPTH];
    logic [OUT_W-1:0] exp_mem [DEPTH];

    logic wr_ok;
    assign wr_ok = we && (32'(waddr) < DEPTH);

    always_ff @(posedge clk) begin
        if (!reset) begin
            vld <= '0;
        end else if (wr_ok) begin
            vld[waddr] <= wdata[VP];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            in_mem[waddr]  <= wdata[IL +: IN_W];
            exp_mem[waddr] <= wdata[EL +: OUT_W];
        end
    end

    always_comb begin
        rdata_hd  = '0;
        rdata_exp = '0;
        if (32'(raddr_hd) < DEPTH) begin
            rdata_hd = {vld[raddr_hd], in_mem[raddr_hd]};
        end
        if (32'(raddr_exp) < DEPTH) begin
            rdata_exp = exp_mem[raddr_exp];
        end
    end
endmodule

// File: rtl/tv_check_engine.sv
// Replays stored vectors into a DUT, holds each for SETTLE cycles, compares the response.
// Latency: SETTLE+1 cycles per vector; N vectors reach DONE N*(SETTLE+1) cycles after start.
// Backpressure: start is ignored and vector writes are dropped while busy.
// Ports: clk, reset (sync, active-low), bus (tv_check_if.slave: load/run/result/DUT pins).
// Optional: define TV_CHECK_ERR_LOG_EN to capture index/response of the first mismatch;
//           otherwise first_err_* read as 0.
module tv_check_engine
    import tv_check_pkg::*;
#(
    parameter int IN_W   = 3,
    parameter int OUT_W  = 1,
    parameter int DEPTH  = 16,
    parameter int SETTLE = 1,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int CNT_W  = ADDR_W + 1
) (
    input  logic        clk,
    input  logic        reset,
    tv_check_if.slave   bus
);
    localparam int                SW       = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam logic [SW-1:0]     SETTLE_V = SW'(SETTLE);
    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH - 1);
    localparam int                HD_VP    = IN_W;  // valid bit within the {valid,in} read

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   idx;
    logic [SW-1:0]       settle_cnt;
    logic [IN_W-1:0]     dut_in_q;
    logic [CNT_W-1:0]    vec_cnt_q, err_cnt_q;
    logic                mismatch_q;

    logic                mem_we;
    logic [ADDR_W-1:0]   hd_addr;
    logic [IN_W:0]       hd_rd, hd_head;
    logic [OUT_W-1:0]    exp_rd;
    logic                idle_like, run_go, is_last, miss, advance;

    assign idle_like = (state == IDLE) || (state == DONE);
    assign run_go    = idle_like && bus.start;
    assign mem_we    = bus.vec_we && !bus.busy;
    assign is_last   = (idx == LAST);

    // The head read port serves entry 0 when idle and entry idx+1 in CHECK.
    assign hd_addr = (state == CHECK && !is_last) ? idx + ADDR_W'(1) : '0;

    // A write to entry 0 in the same cycle as start must be seen by this run.
    assign hd_head = (mem_we && bus.vec_waddr == '0) ? bus.vec_wdata[IN_W+OUT_W:OUT_W] : hd_rd;

    // Case-inequality so X/Z on the DUT pins count as failures in simulation.
    assign miss    = (state == CHECK) && (bus.dut_out !== exp_rd);
    assign advance = !is_last && hd_rd[HD_VP];

    tv_vec_mem #(
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk       (clk),
        .reset     (reset),
        .we        (mem_we),
        .waddr     (bus.vec_waddr),
        .wdata     (bus.vec_wdata),
        .raddr_hd  (hd_addr),
        .rdata_hd  (hd_rd),
        .raddr_exp (idx),
        .rdata_exp (exp_rd)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (bus.start) state_nxt = hd_head[HD_VP] ? WAIT : DONE;
            WAIT:       if (settle_cnt == SW'(1)) state_nxt = CHECK;
            CHECK:      state_nxt = advance ? WAIT : DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            idx        <= '0;
            settle_cnt <= '0;
            dut_in_q   <= '0;
            vec_cnt_q  <= '0;
            err_cnt_q  <= '0;
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        idx       <= '0;
                        vec_cnt_q <= '0;
                        err_cnt_q <= '0;
                        if (hd_head[HD_VP]) begin
                            dut_in_q   <= hd_head[IN_W-1:0];
                            settle_cnt <= SETTLE_V;
                        end
                    end
                end
                WAIT: settle_cnt <= settle_cnt - SW'(1);
                CHECK: begin
                    vec_cnt_q <= vec_cnt_q + CNT_W'(1);
                    if (miss) begin
                        err_cnt_q  <= err_cnt_q + CNT_W'(1);
                        mismatch_q <= 1'b1;
                    end
                    if (advance) begin
                        idx        <= idx + ADDR_W'(1);
                        dut_in_q   <= hd_rd[IN_W-1:0];
                        settle_cnt <= SETTLE_V;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.dut_in    = dut_in_q;
    assign bus.busy      = (state == WAIT) || (state == CHECK);
    assign bus.done      = (state == DONE);
    assign bus.pass      = (state == DONE) && (err_cnt_q == '0);
    assign bus.mismatch  = mismatch_q;
    assign bus.vec_count = vec_cnt_q;
    assign bus.err_count = err_cnt_q;

`ifdef TV_CHECK_ERR_LOG_EN
    logic              fe_vld;
    logic [ADDR_W-1:0] fe_idx;
    logic [OUT_W-1:0]  fe_got;

    always_ff @(posedge clk) begin
        if (!reset || run_go) begin
            fe_vld <= 1'b0;
            fe_idx <= '0;
            fe_got <= '0;
        end else if (miss && !fe_vld) begin
            fe_vld <= 1'b1;
            fe_idx <= idx;
            fe_got <= bus.dut_out;
        end
    end

    assign bus.first_err_valid = fe_vld;
    assign bus.first_err_idx   = fe_idx;
    assign bus.first_err_got   = fe_got;
`else
    logic unused_run_go;
    assign unused_run_go       = run_go;
    assign bus.first_err_valid = 1'b0;
    assign bus.first_err_idx   = '0;
    assign bus.first_err_got   = '0;
`endif
endmodule

// File: tb/tb_tv_check_engine.sv
// Directed bench for tv_check_engine: 3-input XOR DUT, 8-entry store, SETTLE=1.
// Latency under test: 2 cycles per vector.
// Backpressure under test: writes and start while busy are ignored.
module tb_tv_check_engine;
    localparam int IN_W = 3, OUT_W = 1, DEPTH = 8, SETTLE = 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc;
    int   mm;

    always #5 clk = ~clk;

    tv_check_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) bus ();

    assign bus.dut_out = ^bus.dut_in;

    tv_check_engine #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_vec(input int addr, input bit v, input logic [2:0] a, input logic e);
        bus.vec_we    = 1'b1;
        bus.vec_waddr = 3'(addr);
        bus.vec_wdata = {v, a, e};
        tick();
        bus.vec_we = 1'b0;
    endtask

    // Loads n correct vectors (entry i: in=i, exp=parity(i)); bad_mask flips expected.
    task automatic load(input int n, input logic [7:0] bad_mask);
        for (int i = 0; i < n; i++) begin
            logic [2:0] a;
            a = 3'(i);
            write_vec(i, 1'b1, a, (^a) ^ bad_mask[i]);
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Waits for done, counting cycles since start was sampled and mismatch pulses.
    task automatic wait_done(input int start_cyc);
        cyc = start_cyc;
        forever begin
            if (bus.mismatch) mm++;
            if (bus.done || cyc >= 200) break;
            tick();
            cyc++;
        end
        if (!bus.done) begin
            errors++;
            $display("FAIL wait_done timeout: done=%0b after %0d cycles, required 1", bus.done, cyc);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.dut_in, bus.busy, bus.done, bus.pass, bus.mismatch, bus.vec_count,
             bus.err_count, bus.first_err_valid, bus.first_err_idx, bus.first_err_got} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: dut_in=%0h busy=%0b done=%0b pass=%0b vc=%0d ec=%0d, required all 0",
                     bus.dut_in, bus.busy, bus.done, bus.pass, bus.vec_count, bus.err_count);
        end
    endtask

    task automatic test_all_pass();
        load(8, 8'h00);
        mm = 0;
        pulse_start();
        wait_done(0);
        checks++;
        if (cyc !== 16) begin errors++; $display("FAIL pass_latency: got %0d required 16", cyc); end
        checks++;
        if (bus.vec_count !== 4'd8) begin errors++; $display("FAIL pass_vec_count: got %0d required 8", bus.vec_count); end
        checks++;
        if (bus.err_count !== 4'd0 || bus.pass !== 1'b1) begin
            errors++; $display("FAIL pass_result: err=%0d pass=%0b required 0/1", bus.err_count, bus.pass);
        end
        checks++;
        if (mm !== 0) begin errors++; $display("FAIL pass_mismatch_pulses: got %0d required 0", mm); end
        checks++;
        if (bus.dut_in !== 3'd7) begin errors++; $display("FAIL pass_dut_in_hold: got %0d required 7", bus.dut_in); end
    endtask

    task automatic test_errors();
        load(8, 8'b0010_0100);
        mm = 0;
        pulse_start();
        wait_done(0);
        checks++;
        if (bus.err_count !== 4'd2 || bus.pass !== 1'b0) begin
            errors++; $display("FAIL err_result: err=%0d pass=%0b required 2/0", bus.err_count, bus.pass);
        end
        checks++;
        if (mm !== 2) begin errors++; $display("FAIL err_mismatch_pulses: got %0d required 2", mm); end
        checks++;
        if (bus.vec_count !== 4'd8 || cyc !== 16) begin
            errors++; $display("FAIL err_count_latency: vc=%0d cyc=%0d required 8/16", bus.vec_count, cyc);
        end
`ifdef TV_CHECK_ERR_LOG_EN
        checks++;
        if (bus.first_err_valid !== 1'b1 || bus.first_err_idx !== 3'd2 || bus.first_err_got !== 1'b1) begin
            errors++; $display("FAIL first_err: v=%0b idx=%0d got=%0b required 1/2/1",
                               bus.first_err_valid, bus.first_err_idx, bus.first_err_got);
        end
`else
        checks++;
        if (bus.first_err_valid !== 1'b0 || bus.first_err_idx !== 3'd0 || bus.first_err_got !== 1'b0) begin
            errors++; $display("FAIL first_err_tied: v=%0b idx=%0d got=%0b required 0/0/0",
                               bus.first_err_valid, bus.first_err_idx, bus.first_err_got);
        end
`endif
    endtask

    task automatic test_partial();
        load(3, 8'h00);
        write_vec(3, 1'b0, 3'd3, 1'b0);
        mm = 0;
        pulse_start();
        wait_done(0);
        checks++;
        if (cyc !== 6 || bus.vec_count !== 4'd3) begin
            errors++; $display("FAIL partial: cyc=%0d vc=%0d required 6/3", cyc, bus.vec_count);
        end
        checks++;
        if (bus.pass !== 1'b1) begin errors++; $display("FAIL partial_pass: got %0b required 1", bus.pass); end
    endtask

    task automatic test_empty();
        do_reset();
        pulse_start();
        wait_done(0);
        checks++;
        if (cyc > 1 || bus.pass !== 1'b1 || bus.vec_count !== 4'd0) begin
            errors++; $display("FAIL empty: cyc=%0d pass=%0b vc=%0d required <=1/1/0", cyc, bus.pass, bus.vec_count);
        end
    endtask

    task automatic test_reset_midrun();
        load(8, 8'h00);
        pulse_start();
        cyc = 0;
        while (bus.vec_count != 4'd4 && cyc < 100) begin tick(); cyc++; end
        checks++;
        if (bus.dut_in !== 3'd4 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL midrun_vec4: dut_in=%0d busy=%0b required 4/1", bus.dut_in, bus.busy);
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({bus.dut_in, bus.busy, bus.done, bus.pass, bus.mismatch, bus.vec_count, bus.err_count} !== '0) begin
            errors++; $display("FAIL midrun_reset: dut_in=%0d busy=%0b done=%0b vc=%0d required all 0",
                               bus.dut_in, bus.busy, bus.done, bus.vec_count);
        end
        reset = 1'b1;
        pulse_start();
        checks++;
        if (bus.done !== 1'b1 || bus.vec_count !== 4'd0) begin
            errors++; $display("FAIL midrun_restart: done=%0b vc=%0d required 1/0", bus.done, bus.vec_count);
        end
    endtask

    // Memory is empty here; entry 0 written in the same cycle as start must run.
    task automatic test_write_with_start();
        bus.vec_we    = 1'b1;
        bus.vec_waddr = 3'd0;
        bus.vec_wdata = {1'b1, 3'd6, 1'b0};
        bus.start     = 1'b1;
        tick();
        bus.vec_we = 1'b0;
        bus.start  = 1'b0;
        checks++;
        if (bus.dut_in !== 3'd6 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL write_start_dut_in: dut_in=%0d busy=%0b required 6/1", bus.dut_in, bus.busy);
        end
        mm = 0;
        wait_done(0);
        checks++;
        if (cyc !== 2 || bus.vec_count !== 4'd1 || bus.pass !== 1'b1) begin
            errors++; $display("FAIL write_start_run: cyc=%0d vc=%0d pass=%0b required 2/1/1", cyc, bus.vec_count, bus.pass);
        end
    endtask

    task automatic test_busy_ignore();
        load(8, 8'b0010_0100);
        mm = 0;
        pulse_start();
        // In WAIT: try to corrupt entry 3 and restart the run.
        bus.vec_we    = 1'b1;
        bus.vec_waddr = 3'd3;
        bus.vec_wdata = {1'b1, 3'd3, 1'b1};
        bus.start     = 1'b1;
        tick();
        bus.vec_we = 1'b0;
        bus.start  = 1'b0;
        wait_done(1);
        checks++;
        if (cyc !== 16 || bus.vec_count !== 4'd8) begin
            errors++; $display("FAIL busy_start_ignored: cyc=%0d vc=%0d required 16/8", cyc, bus.vec_count);
        end
        checks++;
        if (bus.err_count !== 4'd2 || mm !== 2) begin
            errors++; $display("FAIL busy_write_ignored: err=%0d pulses=%0d required 2/2", bus.err_count, mm);
        end
        mm = 0;
        pulse_start();
        wait_done(0);
        checks++;
        if (cyc !== 16 || bus.vec_count !== 4'd8 || bus.err_count !== 4'd2 || mm !== 2) begin
            errors++; $display("FAIL back_to_back: cyc=%0d vc=%0d err=%0d pulses=%0d required 16/8/2/2",
                               cyc, bus.vec_count, bus.err_count, mm);
        end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.vec_we    = 1'b0;
        bus.vec_waddr = '0;
        bus.vec_wdata = '0;
        test_reset();
        test_all_pass();
        test_errors();
        test_partial();
        test_empty();
        test_reset_midrun();
        test_write_with_start();
        test_busy_ignore();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
